// File: rtl/i2c_master_fifo.sv
// Single-master I2C controller with TX/RX byte FIFOs; open-drain SCL/SDA,
// fixed quarter-period bit timing, no clock stretching or arbitration.

module i2c_master_fifo_buf #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          push_ok, pop_ok;

    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? 8'h00 : mem[rptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            if (push_ok && !pop_ok)      cnt <= cnt + (AW+1)'(1);
            else if (!push_ok && pop_ok) cnt <= cnt - (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; emptiness comes from cnt and dout is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end
endmodule

module i2c_master_fifo #(
    parameter int DIV_Q      = 25,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       slv_addr,
    input  logic [LEN_W-1:0] byte_len,
    input  logic             tx_wr,
    input  logic [7:0]       tx_data,
    output logic             tx_full,
    input  logic             rx_rd,
    output logic [7:0]       rx_data,
    output logic             rx_empty,
    output logic             busy,
    output logic             done,
    output logic             nack,
    inout  wire              scl,
    inout  wire              sda
);
    localparam int QW = $clog2(DIV_Q);
    localparam logic [QW-1:0]    Q_LAST  = QW'(DIV_Q - 1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_ADDR, ST_ADDR_ACK, ST_WR_BYTE,
        ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK, ST_STOP
    } state_t;

    state_t           st, st_nxt;
    logic [QW-1:0]    qcnt;
    logic [1:0]       phase;
    logic [2:0]       bitcnt;
    logic [7:0]       shreg;
    logic [LEN_W-1:0] rem;
    logic             rw_q, sda_s, sda_in;
    logic             scl_oe, sda_oe;
    logic             tx_pop, rx_push, nack_set, rem_dec;
    logic             tx_empty, rx_full;
    logic [7:0]       tx_head;
    logic             qend, sample_pt, cell_end;

    i2c_master_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx (
        .clk(clk), .rstn(rstn), .push(tx_wr), .din(tx_data), .pop(tx_pop),
        .dout(tx_head), .full(tx_full), .empty(tx_empty)
    );

    i2c_master_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx (
        .clk(clk), .rstn(rstn), .push(rx_push), .din(shreg), .pop(rx_rd),
        .dout(rx_data), .full(rx_full), .empty(rx_empty)
    );

    assign scl       = scl_oe ? 1'b0 : 1'bz;
    assign sda       = sda_oe ? 1'b0 : 1'bz;
    assign sda_in    = sda;
    assign busy      = (st != ST_IDLE);
    assign qend      = (qcnt == Q_LAST);
    assign sample_pt = qend && (phase == 2'd2);
    assign cell_end  = qend && (phase == 2'd3);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st <= ST_IDLE;
        else       st <= st_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        st_nxt   = st;
        scl_oe   = 1'b0;
        sda_oe   = 1'b0;
        tx_pop   = 1'b0;
        rx_push  = 1'b0;
        nack_set = 1'b0;
        rem_dec  = 1'b0;
        unique case (st)
            ST_IDLE: if (start) st_nxt = ST_START;
            ST_START: begin
                sda_oe = phase[1];
                if (cell_end) st_nxt = ST_ADDR;
            end
            ST_ADDR, ST_WR_BYTE: begin
                scl_oe = ~phase[1];
                sda_oe = ~shreg[7];
                if (cell_end && bitcnt == 3'd7)
                    st_nxt = (st == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
            end
            ST_ADDR_ACK: begin
                scl_oe = ~phase[1];
                if (cell_end) begin
                    if (sda_s) begin
                        nack_set = 1'b1;
                        st_nxt   = ST_STOP;
                    end else if (rem == '0) begin
                        st_nxt = ST_STOP;
                    end else if (rw_q) begin
                        st_nxt = ST_RD_BYTE;
                    end else if (tx_empty) begin
                        nack_set = 1'b1;
                        st_nxt   = ST_STOP;
                    end else begin
                        tx_pop = 1'b1;
                        st_nxt = ST_WR_BYTE;
                    end
                end
            end
            ST_WR_ACK: begin
                scl_oe = ~phase[1];
                if (cell_end) begin
                    if (sda_s) begin
                        nack_set = 1'b1;
                        st_nxt   = ST_STOP;
                    end else begin
                        rem_dec = 1'b1;
                        if (rem <= LEN_ONE) begin
                            st_nxt = ST_STOP;
                        end else if (tx_empty) begin
                            nack_set = 1'b1;
                            st_nxt   = ST_STOP;
                        end else begin
                            tx_pop = 1'b1;
                            st_nxt = ST_WR_BYTE;
                        end
                    end
                end
            end
            ST_RD_BYTE: begin
                scl_oe = ~phase[1];
                if (cell_end && bitcnt == 3'd7) begin
                    rx_push = ~rx_full;
                    st_nxt  = ST_RD_ACK;
                end
            end
            ST_RD_ACK: begin
                scl_oe = ~phase[1];
                sda_oe = (rem > LEN_ONE);
                if (cell_end) begin
                    rem_dec = 1'b1;
                    st_nxt  = (rem > LEN_ONE) ? ST_RD_BYTE : ST_STOP;
                end
            end
            ST_STOP: begin
                // SDA low under SCL low, SCL up, SDA up, then one idle quarter.
                scl_oe = (phase == 2'd0);
                sda_oe = ~phase[1];
                if (cell_end) st_nxt = ST_IDLE;
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            qcnt   <= '0;
            phase  <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            rem    <= '0;
            rw_q   <= 1'b0;
            sda_s  <= 1'b0;
            nack   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= (st == ST_STOP) && cell_end;
            if (st == ST_IDLE) begin
                qcnt   <= '0;
                phase  <= '0;
                bitcnt <= '0;
                if (start) begin
                    shreg <= {slv_addr, rw};
                    rem   <= byte_len;
                    rw_q  <= rw;
                    nack  <= 1'b0;
                end
            end else begin
                if (qend) begin
                    qcnt  <= '0;
                    phase <= phase + 2'd1;
                end else begin
                    qcnt <= qcnt + QW'(1);
                end
                if (sample_pt) sda_s <= sda_in;
                if (cell_end && (st == ST_ADDR || st == ST_WR_BYTE || st == ST_RD_BYTE))
                    bitcnt <= bitcnt + 3'd1;
                if (tx_pop)
                    shreg <= tx_head;
                else if (cell_end && (st == ST_ADDR || st == ST_WR_BYTE))
                    shreg <= {shreg[6:0], 1'b0};
                else if (sample_pt && st == ST_RD_BYTE)
                    shreg <= {shreg[6:0], sda_in};
                if (rem_dec)  rem  <= rem - LEN_ONE;
                if (nack_set) nack <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_fifo.sv
// Directed bench for i2c_master_fifo: a behavioural I2C target on the bus,
// a transaction vector table, and hand-written FIFO/reset/busy sequences.

module tb_i2c_master_fifo;
    localparam int DIV_Q = 25;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rstn, start, rw, tx_wr, rx_rd;
    logic [6:0] slv_addr;
    logic [7:0] byte_len, tx_data, rx_data;
    logic       tx_full, rx_empty, busy, done, nack;
    wire        scl, sda;

    pullup (scl);
    pullup (sda);

    logic drv = 1'b0;
    assign sda = drv ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master_fifo #(.DIV_Q(DIV_Q), .FIFO_DEPTH(DEPTH), .LEN_W(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .rw(rw), .slv_addr(slv_addr),
        .byte_len(byte_len), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .busy(busy),
        .done(done), .nack(nack), .scl(scl), .sda(sda)
    );

    // Target model state, sampled on the falling clk edge.
    logic       tgt_present = 1'b0;
    logic [6:0] tgt_addr = 7'h00;
    logic [7:0] tgt_rd [16];
    logic [7:0] bus_q [$];
    logic       ack_q [$];
    logic       in_xfer = 1'b0, is_read = 1'b0, addr_match = 1'b0, rd_nacked = 1'b0;
    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic [7:0] sh = 8'h00;
    int         bitn = 0, byte_idx = 0, cyc = 0, last_rise = -1, first_period = -1;
    int         done_cnt = 0, n_stop = 0;

    always @(negedge clk) begin
        cyc++;
        if (done) done_cnt++;
        if (!rstn) begin
            in_xfer = 1'b0;
            drv     = 1'b0;
        end else if (scl && scl_p && sda_p && !sda) begin
            in_xfer = 1'b1; bitn = 8; byte_idx = -1; sh = 8'h00; rd_nacked = 1'b0;
            addr_match = 1'b0; is_read = 1'b0; last_rise = -1; first_period = -1; drv = 1'b0;
            bus_q.delete();
            ack_q.delete();
        end else if (scl && scl_p && !sda_p && sda) begin
            in_xfer = 1'b0;
            drv     = 1'b0;
            n_stop++;
        end else if (in_xfer && scl && !scl_p) begin
            if (last_rise >= 0 && first_period < 0) first_period = cyc - last_rise;
            last_rise = cyc;
            if (bitn < 8) begin
                sh = {sh[6:0], sda};
                if (bitn == 7) begin
                    bus_q.push_back(sh);
                    if (byte_idx == 0) begin
                        is_read    = sh[0];
                        addr_match = tgt_present && (sh[7:1] == tgt_addr);
                    end
                end
            end else begin
                ack_q.push_back(sda);
                if (is_read && byte_idx > 0 && sda) rd_nacked = 1'b1;
            end
        end else if (in_xfer && !scl && scl_p) begin
            if (bitn == 8) begin
                bitn = 0;
                byte_idx++;
            end else begin
                bitn++;
            end
            if (bitn == 8)
                drv = addr_match && (byte_idx == 0 || !is_read);
            else if (addr_match && is_read && byte_idx > 0 && byte_idx <= 16 && !rd_nacked)
                drv = !tgt_rd[byte_idx-1][7-bitn];
            else
                drv = 1'b0;
        end
        scl_p = scl;
        sda_p = sda;
    end

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        check(name, rx_data, exp);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic pulse_start(input logic r, input logic [6:0] a, input logic [7:0] n);
        @(negedge clk);
        start = 1'b1; rw = r; slv_addr = a; byte_len = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic run_txn(input string name, input logic r, input logic [6:0] a, input logic [7:0] n);
        int d0;
        d0 = done_cnt;
        pulse_start(r, a, n);
        wait_done({name, "_done"}, d0);
        repeat (5) @(negedge clk);
    endtask

    function automatic logic [31:0] bus_at(input int j);
        return (j < bus_q.size()) ? 32'(bus_q[j]) : 32'h100;
    endfunction

    typedef struct packed {
        logic           rw;
        logic [6:0]     addr;
        logic [7:0]     len;
        logic [2:0]     npush;
        logic [3:0][7:0] d;
        logic           present;
        logic           exp_nack;
        logic [2:0]     exp_nbytes;
        logic [3:0][7:0] exp_bus;
        logic [3:0]     exp_acks;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [6:0] a, input logic [7:0] n,
                                input logic [2:0] np, input logic [31:0] d, input logic p,
                                input logic en, input logic [2:0] nb, input logic [31:0] eb,
                                input logic [3:0] ea);
        vec_t v;
        v.rw = r; v.addr = a; v.len = n; v.npush = np; v.d = d; v.present = p;
        v.exp_nack = en; v.exp_nbytes = nb; v.exp_bus = eb; v.exp_acks = ea;
        return v;
    endfunction

    vec_t vecs [8];

    initial begin
        int s0, d0, k;
        vec_t v;
        string tag;

        vecs[0] = mk(1'b0, 7'h50, 8'd2, 3'd2, 32'h0000A55A, 1'b1, 1'b0, 3'd3, 32'h00A55AA0, 4'b0000);
        vecs[1] = mk(1'b1, 7'h50, 8'd3, 3'd0, 32'h00332211, 1'b1, 1'b0, 3'd4, 32'h332211A1, 4'b1000);
        vecs[2] = mk(1'b0, 7'h3C, 8'd1, 3'd0, 32'h00000000, 1'b0, 1'b1, 3'd1, 32'h00000078, 4'b0001);
        vecs[3] = mk(1'b0, 7'h50, 8'd0, 3'd0, 32'h00000000, 1'b1, 1'b0, 3'd1, 32'h000000A0, 4'b0000);
        vecs[4] = mk(1'b0, 7'h50, 8'd1, 3'd0, 32'h00000000, 1'b1, 1'b1, 3'd1, 32'h000000A0, 4'b0000);
        vecs[5] = mk(1'b1, 7'h2A, 8'd1, 3'd0, 32'h00000012, 1'b1, 1'b0, 3'd2, 32'h00001255, 4'b0010);
        vecs[6] = mk(1'b0, 7'h7F, 8'd1, 3'd1, 32'h000000FF, 1'b1, 1'b0, 3'd2, 32'h0000FFFE, 4'b0000);
        vecs[7] = mk(1'b1, 7'h3C, 8'd2, 3'd0, 32'h0000BEEF, 1'b0, 1'b1, 3'd1, 32'h00000079, 4'b0001);

        rstn = 1'b0; start = 1'b0; rw = 1'b0; slv_addr = 7'h00; byte_len = 8'h00;
        tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0;
        for (int i = 0; i < 16; i++) tgt_rd[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack, 0);
        check("rst_tx_full", tx_full, 0);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            tag = $sformatf("v%0d", i);
            tgt_present = v.present;
            tgt_addr    = v.addr;
            for (int j = 0; j < 4; j++) tgt_rd[j] = v.d[j];
            for (int j = 0; j < int'(v.npush); j++) push(v.d[j]);
            s0 = n_stop;
            run_txn(tag, v.rw, v.addr, v.len);
            check({tag, "_nack"}, nack, v.exp_nack);
            check({tag, "_busy"}, busy, 0);
            check({tag, "_stop"}, n_stop - s0, 1);
            check({tag, "_scl_period"}, first_period, 4 * DIV_Q);
            check({tag, "_nbytes"}, bus_q.size(), v.exp_nbytes);
            check({tag, "_nacks"}, ack_q.size(), v.exp_nbytes);
            for (int j = 0; j < int'(v.exp_nbytes); j++) begin
                check($sformatf("%s_bus%0d", tag, j), bus_at(j), v.exp_bus[j]);
                check($sformatf("%s_ack%0d", tag, j),
                      (j < ack_q.size()) ? 32'(ack_q[j]) : 32'h2, v.exp_acks[j]);
            end
            if (v.rw && !v.exp_nack)
                for (int j = 0; j < int'(v.len); j++) pop_chk($sformatf("%s_rx%0d", tag, j), v.d[j]);
            check({tag, "_rx_empty"}, rx_empty, 1);
        end

        // TX FIFO fill: eighth push sets full, ninth is dropped, write of 9 runs dry.
        tgt_present = 1'b1; tgt_addr = 7'h50;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            push(8'(i));
            check($sformatf("fill_full%0d", i), tx_full, (i >= DEPTH) ? 1 : 0);
        end
        run_txn("fill", 1'b0, 7'h50, 8'd9);
        check("fill_nack", nack, 1);
        check("fill_nbytes", bus_q.size(), 9);
        check("fill_bus0", bus_at(0), 32'hA0);
        for (int j = 1; j <= DEPTH; j++) check($sformatf("fill_bus%0d", j), bus_at(j), j);
        check("fill_tx_full", tx_full, 0);

        // RX overflow: ninth received byte is dropped, transaction still completes.
        for (int i = 0; i < 9; i++) tgt_rd[i] = 8'hC0 + 8'(i);
        s0 = n_stop;
        run_txn("rxovf", 1'b1, 7'h50, 8'd9);
        check("rxovf_nack", nack, 0);
        check("rxovf_nbytes", bus_q.size(), 10);
        check("rxovf_stop", n_stop - s0, 1);
        for (int j = 0; j < DEPTH; j++) pop_chk($sformatf("rxovf_rx%0d", j), 8'hC0 + 8'(j));
        check("rxovf_empty", rx_empty, 1);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
        check("rd_empty_ignored", rx_empty, 1);
        check("rd_empty_data", rx_data, 0);

        // Start pulsed mid-transaction must be ignored.
        push(8'h3C);
        d0 = done_cnt;
        pulse_start(1'b0, 7'h50, 8'd1);
        repeat (1000) @(negedge clk);
        check("busy_mid", busy, 1);
        pulse_start(1'b1, 7'h3C, 8'd5);
        wait_done("busy_done", d0);
        repeat (600) @(negedge clk);
        check("busy_one_done", done_cnt - d0, 1);
        check("busy_idle", busy, 0);
        check("busy_nbytes", bus_q.size(), 2);
        check("busy_bus0", bus_at(0), 32'hA0);
        check("busy_bus1", bus_at(1), 32'h3C);
        check("busy_nack", nack, 0);

        // Reset during the fourth data bit releases the bus at once.
        push(8'hF0);
        push(8'h0F);
        d0 = done_cnt;
        pulse_start(1'b0, 7'h50, 8'd2);
        k = 0;
        while (!(in_xfer && byte_idx == 1 && bitn == 3 && scl) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("abort_reached", 32'(k < 5000), 1);
        rstn = 1'b0;
        #1;
        check("abort_scl", scl, 1);
        check("abort_sda", sda, 1);
        check("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_rx_empty", rx_empty, 1);
        push(8'h81);
        run_txn("after", 1'b0, 7'h50, 8'd1);
        check("after_nack", nack, 0);
        check("after_nbytes", bus_q.size(), 2);
        check("after_bus0", bus_at(0), 32'hA0);
        check("after_bus1", bus_at(1), 32'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_master_fifo.md
I2C_MASTER_FIFO -- requirements
Module: i2c_master_fifo

Interface
REQ-001 SHALL have parameter DIV_Q, default 25, meaning clk cycles per SCL quarter-period (SCL period = 4*DIV_Q clk cycles), legal range 2..1023.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning entries in each of TX and RX FIFO, power of two, 2..64.
REQ-003 SHALL have parameter LEN_W, default 8, meaning width of byte-count field.
REQ-004 SHALL have port clk, input, 1, meaning the single clock (100 MHz nominal).
REQ-005 SHALL have port rstn, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, meaning single-cycle transaction request, honoured only in IDLE.
REQ-007 SHALL have port rw, input, 1, meaning transaction direction, 0 = write and 1 = read, sampled with start.
REQ-008 SHALL have port slv_addr, input, 7, meaning 7-bit target address, sampled with start.
REQ-009 SHALL have port byte_len, input, LEN_W, meaning data bytes to transfer, sampled with start; 0 = address-only probe.
REQ-010 SHALL have port tx_wr, input, 1, meaning push tx_data into the TX FIFO.
REQ-011 SHALL have port tx_data, input, 8, meaning TX FIFO write data.
REQ-012 SHALL have port tx_full, output, 1, meaning TX FIFO full.
REQ-013 SHALL have port rx_rd, input, 1, meaning pop the RX FIFO.
REQ-014 SHALL have port rx_data, output, 8, meaning RX FIFO head, valid while rx_empty=0.
REQ-015 SHALL have port rx_empty, output, 1, meaning RX FIFO empty.
REQ-016 SHALL have ports busy, done, and nack, each output, 1: busy = not IDLE; done = 1-cycle pulse at end of STOP; nack = sticky target-NACK flag, cleared on next accepted start.
REQ-017 SHALL have ports scl and sda, each inout, 1, open-drain (drive 0 or z only), external pull-ups required on both.

Function
REQ-018 SHALL run a quarter-phase counter 0..DIV_Q-1 and a phase index 0..3 only while busy; each bit cell consists of q0 SCL low with SDA change, q1 SCL low, q2 SCL high, and q3 SCL high with sda sampled at the end of q2.
REQ-019 SHALL use FSM states IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP.
REQ-020 SHALL go from IDLE on start=1 to START on the next clk edge; START SHALL release SDA/SCL for 2 quarters, pull SDA low for 2 quarters, then go to ADDR.
REQ-021 SHALL shift ADDR MSB first as {slv_addr, rw} over 8 bit cells and then enter ADDR_ACK, releasing SDA for one bit cell.
REQ-022 SHALL, on ACK (sda=0) in ADDR_ACK, enter STOP if byte_len=0, WR_BYTE if rw=0, or RD_BYTE if rw=1; on NACK it SHALL set nack and enter STOP.
REQ-023 SHALL pop the TX FIFO at WR_BYTE entry; if the TX FIFO is empty at that point, SHALL set nack and enter STOP without sending.
REQ-024 SHALL, in WR_ACK, decrement the remaining count on ACK, going to WR_BYTE if remaining>0 and otherwise to STOP; on NACK it SHALL set nack and go to STOP.
REQ-025 SHALL, in RD_BYTE, sample 8 bits MSB first and push the byte into the RX FIFO at the end of the cell.
REQ-026 SHALL, in RD_ACK, drive SDA low (ACK) if remaining>1 and release it (NACK) on the last byte; it SHALL then go to RD_BYTE or STOP accordingly.
REQ-027 SHALL, in STOP, pull SDA low with SCL low, release SCL, then release SDA while SCL is high, with each step lasting 1 quarter and a final idle quarter, then pulse done and return to IDLE.
REQ-028 SHALL ignore start while busy.
REQ-029 SHALL ignore tx_wr when full (data dropped), ignore rx_rd when empty, and ignore an RX push when the RX FIFO is full, with the byte dropped and the transaction continuing.
REQ-030 SHALL perform both operations on simultaneous push+pop on a non-full/non-empty FIFO, leaving count unchanged.
REQ-031 SHALL wrap FIFO pointers modulo FIFO_DEPTH and derive full/empty from a count of width log2(FIFO_DEPTH)+1.
REQ-032 SHALL not support clock stretching or arbitration; SCL input is not monitored.

Reset
REQ-033 SHALL, on rstn=0 and regardless of clk, go to IDLE with scl=z, sda=z, busy=0, done=0, nack=0, tx_full=0, rx_empty=1, rx_data=0, both FIFOs empty, and all counters 0.
REQ-034 SHALL, on reset asserted mid-transaction, release the bus immediately with no STOP generated, and after rstn rises accept the next start normally.

Verification
REQ-035 SHALL pass a scenario where 0x5A,0xA5 are pushed and start with rw=0, slv_addr=0x50, byte_len=2 is applied against an ACKing model, giving bus bytes 0xA0,0x5A,0xA5, done pulse, nack=0, and SCL period 100 clk.
REQ-036 SHALL pass a scenario where start with rw=1, slv_addr=0x50, byte_len=3 is applied with the target returning 0x11,0x22,0x33, giving master ACK,ACK,NACK and RX FIFO pops 0x11,0x22,0x33, then rx_empty=1.
REQ-037 SHALL pass a scenario where start with slv_addr=0x3C is applied and no device answers, giving address NACK, nack=1, STOP issued, and no data cells.
REQ-038 SHALL pass a scenario where FIFO_DEPTH+1 TX pushes are made, giving tx_full=1 after the 8th push, the 9th dropped, and the later write of byte_len=9 sending 8 bytes then stopping with nack=1.
REQ-039 SHALL pass a scenario where rstn is pulled low during the 4th data bit of a write, giving scl=z and sda=z within the same cycle and busy=0, with a following write completing correctly.
REQ-040 SHALL pass a scenario where start is pulsed while busy, with no effect on the ongoing transaction and exactly one done pulse.
